// File: rtl/cond_sum_seq_adder_ctrl_pkg.sv
// Shared constants and FSM encoding for the sequential conditional-sum adder controllers.
package cond_sum_seq_adder_ctrl_pkg;

    localparam int unsigned DEF_BLOCK_LEN = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } adder_state_e;

endpackage

// File: rtl/cond_sum_block_slice.sv
// Combinational conditional-sum block: forms carry-in 0 and 1 results, then picks one.
module cond_sum_block_slice #(
    parameter int unsigned BLOCK_LEN = 4
) (
    input  logic [BLOCK_LEN-1:0] a_k,
    input  logic [BLOCK_LEN-1:0] b_k,
    input  logic                 sel_carry,
    output logic [BLOCK_LEN-1:0] sum_k,
    output logic                 cout_k
);

    logic [BLOCK_LEN:0] res0;
    logic [BLOCK_LEN:0] res1;

    assign res0 = {1'b0, a_k} + {1'b0, b_k};
    assign res1 = {1'b0, a_k} + {1'b0, b_k} + {{BLOCK_LEN{1'b0}}, 1'b1};

    always_comb begin
        if (sel_carry) begin
            sum_k  = res1[BLOCK_LEN-1:0];
            cout_k = res1[BLOCK_LEN];
        end else begin
            sum_k  = res0[BLOCK_LEN-1:0];
            cout_k = res0[BLOCK_LEN];
        end
    end

endmodule

// File: rtl/cond_sum_seq_adder_ctrl.sv
// Multi-cycle wide adder: one conditional-sum block per cycle, LSB block first,
// with the registered running carry choosing between the two block results.
module cond_sum_seq_adder_ctrl
    import cond_sum_seq_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BLOCK_LEN = DEF_BLOCK_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NUM_BLK = WIDTH / BLOCK_LEN;
    localparam int unsigned CntW    = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_BLK - 1);

    adder_state_e state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [BLOCK_LEN-1:0] a_blk;
    logic [BLOCK_LEN-1:0] b_blk;
    logic [BLOCK_LEN-1:0] slice_sum;
    logic                 slice_carry;

    // Constant-index slice mux keeps the block select free of variable part-selects.
    always_comb begin
        a_blk = '0;
        b_blk = '0;
        for (int unsigned k = 0; k < NUM_BLK; k++) begin
            if (cnt_q == CntW'(k)) begin
                a_blk = a_q[k*BLOCK_LEN +: BLOCK_LEN];
                b_blk = b_q[k*BLOCK_LEN +: BLOCK_LEN];
            end
        end
    end

    cond_sum_block_slice #(
        .BLOCK_LEN (BLOCK_LEN)
    ) u_slice (
        .a_k       (a_blk),
        .b_k       (b_blk),
        .sel_carry (carry_q),
        .sum_k     (slice_sum),
        .cout_k    (slice_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int unsigned k = 0; k < NUM_BLK; k++) begin
                    if (cnt_q == CntW'(k)) begin
                        sum_d[k*BLOCK_LEN +: BLOCK_LEN] = slice_sum;
                    end
                end
                carry_d = slice_carry;
                if (cnt_q == LastCnt) begin
                    cout_d  = slice_carry;
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun) || (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cond_sum_seq_adder_ctrl.sv
// Scoreboard bench for cond_sum_seq_adder_ctrl at WIDTH=16, BLOCK_LEN=4.
module tb_cond_sum_seq_adder_ctrl;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned BLOCK_LEN = 4;
    localparam int unsigned NUM_BLK   = WIDTH / BLOCK_LEN;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int tests_run = 0;
    int fails     = 0;
    logic [WIDTH:0] exp_q[$];

    cond_sum_seq_adder_ctrl #(
        .WIDTH     (WIDTH),
        .BLOCK_LEN (BLOCK_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; optionally pokes in_valid while DONE is held or
    // while the output handshake completes, to show those requests are ignored.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input int gap, input bit pulse_hold,
                          input bit simul_in);
        int waitc = 0;
        int lat;
        logic [WIDTH:0] held;
        logic [WIDTH:0] expv;
        while (in_ready !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
            fails++;
        end
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        exp_q.push_back({1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv});
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        tests_run++;
        if (lat != NUM_BLK + 1) begin
            $display("FAIL latency: got %0d edges required %0d", lat, NUM_BLK + 1);
            fails++;
        end
        held = {cout, sum};
        for (int i = 0; i < gap; i++) begin
            if (pulse_hold) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                in_valid = (i % 2) == 0;
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || {cout, sum} !== held || in_ready !== 1'b0) begin
                $display("FAIL hold: out_valid=%b in_ready=%b res=%h required 1 0 %h",
                         out_valid, in_ready, {cout, sum}, held);
                fails++;
            end
        end
        in_valid = 1'b0;
        expv = exp_q.pop_front();
        tests_run++;
        if ({cout, sum} !== expv || out_valid !== 1'b1) begin
            $display("FAIL result a=%h b=%h cin=%b: got cout,sum=%h valid=%b required %h",
                     av, bv, cv, {cout, sum}, out_valid, expv);
            fails++;
        end
        out_ready = 1'b1;
        if (simul_in) begin
            a = 16'h0F0F;
            b = 16'h0F0F;
            in_valid = 1'b1;
        end
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL out_handshake: out_valid=%b busy=%b in_ready=%b required 0 0 1",
                     out_valid, busy, in_ready);
            fails++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== '0 || cout !== 1'b0) begin
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b required 1 0 0 0 0",
                     in_ready, out_valid, busy, sum, cout);
            fails++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_op(16'h1234, 16'h0101, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ripple();
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(16'h8000, 16'h8000, 1'b0, 10, 1'b1, 1'b0);
    endtask

    task automatic test_done_simul();
        run_op(16'h00FF, 16'h0001, 1'b0, 2, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        while (in_ready !== 1'b1 && seen < 20) begin
            tick();
            seen++;
        end
        a = 16'hABCD;
        b = 16'h1111;
        cin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            sum !== '0 || cout !== 1'b0) begin
            $display("FAIL reset_mid: in_ready=%b busy=%b out_valid=%b sum=%h cout=%b required 1 0 0 0 0",
                     in_ready, busy, out_valid, sum, cout);
            fails++;
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            $display("FAIL reset_mid_no_valid: out_valid seen %0d cycles required 0", seen);
            fails++;
        end
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_done_simul();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
